// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default sizes for the multi-channel PWM generator
package pwm_pkg;
   localparam int PWM_WIDTH    = 8;
   localparam int PWM_CHANNELS = 4;
   typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: double-buffered duty compare with enable/polarity and registered output
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] counter,
   input  logic             boundary,
   input  logic             load,
   input  logic [WIDTH-1:0] load_duty,
   input  logic             enable,
   input  logic             invert,
   output logic             pwm
);
   logic [WIDTH-1:0] shadow_duty, active_duty, duty_cur;
   // the boundary cycle already compares against the duty it is about to latch
   assign duty_cur = boundary ? shadow_duty : active_duty;
   always_ff @(posedge clock_in or negedge reset_n)
      if (!reset_n) begin
         shadow_duty <= '0;
         active_duty <= '0;
         pwm         <= 1'b0;
      end else begin
         shadow_duty <= load ? load_duty : shadow_duty;
         active_duty <= duty_cur;
         pwm         <= (enable & (counter < duty_cur)) ^ invert;
      end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared edge/center-aligned period counter driving CHANNELS compare channels
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int WIDTH    = PWM_WIDTH,
   parameter int CHANNELS = PWM_CHANNELS,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock_in,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    period,
   input  logic                center_mode,
   input  logic                load_en,
   input  logic [CH_W-1:0]     load_ch,
   input  logic [WIDTH-1:0]    load_duty,
   input  logic [CHANNELS-1:0] ch_enable,
   input  logic [CHANNELS-1:0] ch_invert,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start
);
   logic [WIDTH-1:0] counter, counter_nxt, period_act, period_eff;
   pwm_mode_e        mode_act, mode_eff;
   logic             down, down_eff, down_nxt, boundary, at_top;
   assign boundary = (counter == '0);
   // new period/mode apply from the boundary cycle itself, so a period always restarts going up
   always_comb begin
      period_eff  = boundary ? period : period_act;
      mode_eff    = boundary ? pwm_mode_e'(center_mode) : mode_act;
      down_eff    = boundary ? 1'b0 : down;
      at_top      = !down_eff && (counter == period_eff);
      counter_nxt = (period_eff == '0) ? '0 :
                    down_eff           ? counter - 1'b1 :
                    !at_top            ? counter + 1'b1 :
                    (mode_eff == PWM_CENTER) ? period_eff - 1'b1 : '0;
      down_nxt    = (period_eff != '0) && (down_eff || (at_top && mode_eff == PWM_CENTER));
   end
   always_ff @(posedge clock_in or negedge reset_n)
      if (!reset_n) begin
         counter      <= '0;
         down         <= 1'b0;
         period_act   <= '0;
         mode_act     <= PWM_EDGE;
         period_start <= 1'b0;
      end else begin
         counter      <= counter_nxt;
         down         <= down_nxt;
         period_act   <= period_eff;
         mode_act     <= mode_eff;
         period_start <= boundary;
      end
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pwm_channel #(.WIDTH(WIDTH)) u_ch (
         .clock_in  (clock_in),
         .reset_n   (reset_n),
         .counter   (counter),
         .boundary  (boundary),
         .load      (load_en && (load_ch == CH_W'(g))),
         .load_duty (load_duty),
         .enable    (ch_enable[g]),
         .invert    (ch_invert[g]),
         .pwm       (pwm_out[g])
      );
   end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed and random checks of pwm_multi against a per-period reference model
module tb_pwm_multi;
   import pwm_pkg::*;
   localparam int W = PWM_WIDTH;
   localparam int N = PWM_CHANNELS;
   localparam int CW = 2;
   logic          clock_in = 1'b0;
   logic          reset_n = 1'b0;
   logic [W-1:0]  period = '0;
   logic          center_mode = 1'b0;
   logic          load_en = 1'b0;
   logic [CW-1:0] load_ch = '0;
   logic [W-1:0]  load_duty = '0;
   logic [N-1:0]  ch_enable = '0;
   logic [N-1:0]  ch_invert = '0;
   logic [N-1:0]  pwm_out;
   logic          period_start;
   logic [2:0]    pwm3;
   logic          ps3;
   int total = 0, bad = 0;
   int t, p_m;
   bit m_m;
   int sh[N], ac[N];
   logic [N-1:0] exp_out;
   logic exp_ps;

   always #5 clock_in = ~clock_in;

   pwm_multi #(.WIDTH(W), .CHANNELS(N)) u_dut (
      .clock_in(clock_in), .reset_n(reset_n), .period(period), .center_mode(center_mode),
      .load_en(load_en), .load_ch(load_ch), .load_duty(load_duty), .ch_enable(ch_enable),
      .ch_invert(ch_invert), .pwm_out(pwm_out), .period_start(period_start));

   // three-channel copy: load_ch==3 is out of range here and must be ignored
   pwm_multi #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
      .clock_in(clock_in), .reset_n(reset_n), .period(period), .center_mode(center_mode),
      .load_en(load_en), .load_ch(load_ch), .load_duty(load_duty), .ch_enable(ch_enable[2:0]),
      .ch_invert(ch_invert[2:0]), .pwm_out(pwm3), .period_start(ps3));

   task automatic check(string tag, int obs, int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      t = 0; p_m = 0; m_m = 0;
      for (int c = 0; c < N; c++) begin sh[c] = 0; ac[c] = 0; end
   endtask

   // model: position t within the current period; counter value derived from t
   task automatic tick(string tag);
      int cnt, len;
      bit b;
      b = (t == 0);
      if (b) begin
         p_m = int'(period); m_m = center_mode;
         for (int c = 0; c < N; c++) ac[c] = sh[c];
      end
      cnt = (m_m && t > p_m) ? 2 * p_m - t : t;
      for (int c = 0; c < N; c++) exp_out[c] = (ch_enable[c] && cnt < ac[c]) ^ ch_invert[c];
      exp_ps = b;
      if (load_en && int'(load_ch) < N) sh[load_ch] = int'(load_duty);
      len = (p_m == 0) ? 1 : m_m ? 2 * p_m : p_m + 1;
      t = (t + 1) % len;
      @(posedge clock_in); #1;
      load_en = 1'b0;
      check({tag, "_out"}, int'(pwm_out), int'(exp_out));
      check({tag, "_ps"}, int'(period_start), int'(exp_ps));
      check({tag, "_out3"}, int'(pwm3), int'(exp_out[2:0]));
      check({tag, "_ps3"}, int'(ps3), int'(exp_ps));
   endtask

   task automatic load(int ch, int d);
      load_en = 1'b1; load_ch = CW'(ch); load_duty = W'(d);
   endtask

   task automatic align();
      int g = 0;
      while (t != 0 && g < 600) begin tick("align"); g++; end
   endtask

   task automatic period_count(int ch, int len, int exp_hi, string tag,
                               int a1 = -1, int d1 = 0, int a2 = -1, int d2 = 0);
      int hc = 0, ps = 0;
      for (int i = 0; i < len; i++) begin
         if (i == a1) load(ch, d1);
         if (i == a2) load(ch, d2);
         tick(tag);
         hc += int'(pwm_out[ch]);
         ps += int'(period_start);
      end
      check({tag, "_high"}, hc, exp_hi);
      check({tag, "_starts"}, ps, 1);
   endtask

   initial begin
      model_reset();
      ch_invert = '1;
      #22;
      check("rst_out", int'(pwm_out), 0);
      check("rst_ps", int'(period_start), 0);
      check("rst_out3", int'(pwm3), 0);
      ch_invert = '0;
      reset_n = 1'b1;
      repeat (5) tick("idle");
      // edge mode P=9, ch0 duty 3
      period = 9; center_mode = 1'b0; ch_enable = '1;
      load(0, 3); tick("e_ld");
      align();
      period_count(0, 10, 3, "edge9");
      period_count(0, 10, 3, "edge9b");
      // center mode P=8, ch1
      period = 8; center_mode = 1'b1;
      load(1, 4); tick("c_ld");
      align();
      period_count(1, 16, 7, "ctr4");
      load(1, 9); tick("c_ld9"); align();
      period_count(1, 16, 16, "ctr9");
      load(1, 0); tick("c_ld0"); align();
      period_count(1, 16, 0, "ctr0");
      // double buffering, edge P=9, ch2
      period = 9; center_mode = 1'b0;
      load(2, 2); tick("db_ld"); align();
      period_count(2, 10, 2, "db_cur", 4, 6);
      period_count(2, 10, 6, "db_next", 0, 1);
      period_count(2, 10, 1, "db_bnd");
      period_count(2, 10, 1, "db_two", 2, 3, 5, 7);
      period_count(2, 10, 7, "db_last");
      // enable / invert on ch3
      load(3, 5); tick("ei_ld"); align();
      tick("ei0"); tick("ei1");
      ch_enable[3] = 1'b0; tick("ei_off");
      check("ei_off_bit", int'(pwm_out[3]), 0);
      ch_invert[3] = 1'b1; tick("ei_inv");
      check("ei_inv_bit", int'(pwm_out[3]), 1);
      ch_enable[3] = 1'b1; ch_invert[3] = 1'b0; tick("ei_on");
      check("ei_on_bit", int'(pwm_out[3]), 1);
      tick("ei_on5");
      check("ei_on5_bit", int'(pwm_out[3]), 0);
      align();
      // P=0: every cycle a boundary
      period = 0; align();
      repeat (4) tick("p0");
      check("p0_ps", int'(period_start), 1);
      check("p0_ch0", int'(pwm_out[0]), 1);
      // P=255, duty 255
      period = 255; load(0, 255); tick("p255_ld"); align();
      period_count(0, 256, 255, "p255");
      // out-of-range load on the three-channel copy
      period = 5; align();
      load(3, 200); tick("oor"); align();
      period_count(0, 6, 6, "oor_p");
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) period = W'($urandom_range(0, 12));
         if ($urandom_range(0, 39) == 0) center_mode = 1'(($urandom));
         if ($urandom_range(0, 3) == 0) load($urandom_range(0, 3), $urandom_range(0, 14));
         if ($urandom_range(0, 19) == 0) ch_enable = N'($urandom);
         if ($urandom_range(0, 19) == 0) ch_invert = N'($urandom);
         tick("rnd");
      end
      // asynchronous reset mid-period
      period = 9; center_mode = 1'b0; ch_invert = '1; ch_enable = '1;
      repeat (3) tick("pre_rst");
      #2 reset_n = 1'b0;
      #1;
      check("arst_out", int'(pwm_out), 0);
      check("arst_ps", int'(period_start), 0);
      check("arst_out3", int'(pwm3), 0);
      model_reset();
      #2 reset_n = 1'b1;
      repeat (12) tick("post_rst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator.
- One shared period counter drives CHANNELS compare channels.
- Duty and period are double-buffered, so updates take effect only at a period boundary and cannot glitch the output.
- Supports edge-aligned and center-aligned counting, with per-channel enable and polarity. Sits between the register/control logic and the output pads or the class-D stage.

Parameters:
- WIDTH, 8, bit width of counter, period and duty values.
- CHANNELS, 4, number of independent PWM outputs.
- CH_W, $clog2(CHANNELS) (min 1), width of the channel select.

Ports:
- clock_in  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- period  in  WIDTH  counter terminal value P; sampled at period boundary only
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary only
- load_en  in  1  one-cycle strobe: write load_duty into shadow register of channel load_ch
- load_ch  in  CH_W  target channel for load; values >= CHANNELS are ignored
- load_duty  in  WIDTH  new duty compare value
- ch_enable  in  CHANNELS  per-channel enable, not buffered
- ch_invert  in  CHANNELS  per-channel output polarity, not buffered
- pwm_out  out  CHANNELS  PWM outputs, registered
- period_start  out  1  one-cycle pulse in the first cycle of each period, registered

Behaviour:
- Reset (async assert, sync release)
  - counter=0, direction=up.
  - active period/mode = 0.
  - all shadow and active duties = 0.
  - pwm_out=0 and period_start=0, regardless of ch_invert.
- Boundary: the cycle in which the counter holds 0 at the start of a period.
  - First boundary is the first clock after reset release.
  - At a boundary: period→P_act, center_mode→mode_act, each shadow duty→active duty.
- Edge mode counting: counter 0,1,…,P_act, then back to 0. Period length P_act+1 cycles.
- Center mode counting: counter 0 up to P_act, then down to 1, then back to 0. Period length 2·P_act cycles.
- P_act = 0 (either mode): counter stays 0; every cycle is a boundary.
- Compare: raw[c] = (counter < duty_act[c]), unsigned, full WIDTH. Resulting high cycles per period:
  - Edge mode: min(d, P+1).
  - Center mode: 2d−1 for 1≤d≤P; 2P for d>P; 0 for d=0.
  - d=0 gives a constant low raw signal in both modes.
- Output: pwm_out[c] <= (ch_enable[c] ? raw[c] : 0) ^ ch_invert[c].
  - Latency: 1 cycle from counter value to output.
  - Enable/invert changes appear on the next clock, not buffered.
- period_start is registered with the same 1-cycle latency as pwm_out. It goes high the cycle after the counter is 0 at a boundary. With P_act=0 it stays high continuously.
- Loads
  - A load written in the same cycle as a boundary is captured in the shadow register but is NOT transferred. The transfer at that boundary uses the old shadow value; the new value takes effect at the next boundary.
  - Multiple loads to one channel within a period: last write wins.
  - Out-of-range load_ch: no register changes.
- period or center_mode changing mid-period has no effect until the next boundary. A mode change always restarts at counter=0, direction up.
- Reset asserted mid-period: immediate return to reset values. Shadow contents are lost.

Decomposition:
- Shared package pwm_pkg holds:
  - typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}.
  - the default WIDTH/CHANNELS localparams.
- Sub-module pwm_channel, one instance per channel (generate loop), containing:
  - shadow and active duty registers;
  - compare, enable/invert and output register.
- Counter, direction, boundary logic and active period/mode stay in pwm_multi. Inputs to each pwm_channel: counter, boundary, and that channel's load strobe.

Test Plan:
- Reset/idle: hold reset_n=0 with ch_invert=4'hF → pwm_out=0 and period_start=0. After release with all duties 0 and invert=0 → pwm_out stays 0.
- Edge mode, P=9, ch0 duty=3, enabled:
  - period_start pulses every 10 cycles.
  - pwm_out[0] is high 3 cycles then low 7, starting 1 cycle after the counter is 0.
- Center mode, P=8, ch1 duty=4:
  - period is 16 cycles; pwm_out[1] is high 7 cycles per period (counter values 3,2,1,0,1,2,3).
  - duty=9 → constant high; duty=0 → constant low.
- Double buffering:
  - Load ch2 duty 2→6 mid-period → current period still shows 2 high cycles; the next period shows 6.
  - A load in the boundary cycle takes effect one period later.
  - Two loads in one period → only the last is applied.
- Enable/invert: ch3 duty=5, P=9.
  - Clear ch_enable[3] → output 0 on the next clock.
  - Also set ch_invert[3] → constant 1.
  - Re-enable → the waveform resumes mid-period without waiting for a boundary.
- Corners:
  - P=0 → period_start constant high; duty≥1 gives constant high.
  - P=255 with duty=255 → output low only when counter=255.
  - load_ch ≥ CHANNELS is ignored.
  - Reset pulse mid-period clears all outputs asynchronously.
